shift_add_multiplier: RTL and testbench

//  Sequential unsigned multiplier built on the 4-bit ripple-carry adder.
//  - Latches A and B on a start pulse.
//  - Each step conditionally adds the multiplicand into the upper half of a

---
 rtl/mult_pkg.sv | 8 +
 rtl/rippercarryadder.sv | 25 ++
 rtl/shift_add_multiplier.sv | 90 +++++++++
 tb/tb_shift_add_multiplier.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier and its adder slices.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  localparam int unsigned ADD_SLICE_W = 4;

endpackage

// File: rtl/rippercarryadder.sv
// 4-bit ripple-carry adder slice; chained through cin0/cout for wider adds.
module rippercarryadder
  import mult_pkg::*;
(
  input  logic [ADD_SLICE_W-1:0] A,
  input  logic [ADD_SLICE_W-1:0] B,
  input  logic                   cin0,
  output logic [ADD_SLICE_W-1:0] sum,
  output logic                   cout
);

  logic [ADD_SLICE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin0;
    for (int i = 0; i < ADD_SLICE_W; i++) begin
      sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end
    cout = c[ADD_SLICE_W];
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one conditional add + right shift per cycle,
// WIDTH steps per product, single-cycle done pulse with the product held until the next start.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NSLICE = WIDTH / ADD_SLICE_W;
  localparam int unsigned CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t        state;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   q_q;
  logic [CW-1:0]      count_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic [NSLICE:0]    carry;
  logic [2*WIDTH-1:0] shifted;

  assign addend   = q_q[0] ? m_q : '0;
  assign carry[0] = 1'b0;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    rippercarryadder u_add (
      .A    (acc_q[k*ADD_SLICE_W +: ADD_SLICE_W]),
      .B    (addend[k*ADD_SLICE_W +: ADD_SLICE_W]),
      .cin0 (carry[k]),
      .sum  (sum[k*ADD_SLICE_W +: ADD_SLICE_W]),
      .cout (carry[k + 1])
    );
  end

  // {carry, sum, Q} >> 1: the top-slice carry lands in the acc MSB, Q[0] drops out.
  assign shifted = {carry[NSLICE], sum, q_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      count_q <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m_q     <= A;
            q_q     <= B;
            acc_q   <= '0;
            count_q <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc_q   <= shifted[2*WIDTH-1:WIDTH];
          q_q     <= shifted[WIDTH-1:0];
          count_q <= count_q + CW'(1);
          if (count_q == LAST) begin
            product <= shifted;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: vector table plus hand-written multi-cycle sequences.
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .A       (a),
    .B       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[8];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int dbl_done  = 0;
  logic done_prev = 1'b0;

  // done must never be high on two consecutive cycles
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev === 1'b1) dbl_done <= dbl_done + 1;
    done_prev <= done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, then wait (bounded) for done; lat counts edges after the start edge.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        output int lat, output bit busy_ok);
    a     = xa;
    b     = xb;
    start = 1'b1;
    tick();
    start   = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit busy_ok;
    int extra;
    int gap;

    vecs[0] = '{a: 4'd6,  b: 4'd11, p: 8'd66};
    vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'd225};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
    vecs[3] = '{a: 4'd9,  b: 4'd0,  p: 8'd0};
    vecs[4] = '{a: 4'd1,  b: 4'd1,  p: 8'd1};
    vecs[5] = '{a: 4'd15, b: 4'd1,  p: 8'd15};
    vecs[6] = '{a: 4'd8,  b: 4'd8,  p: 8'd64};
    vecs[7] = '{a: 4'd13, b: 4'd7,  p: 8'd91};

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("reset_product", 32'(product), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, busy_ok);
      check($sformatf("vec%0d_latency", i), 32'(lat), 4);
      check($sformatf("vec%0d_busy_in_run", i), 32'(busy_ok), 1);
      check($sformatf("vec%0d_product", i), 32'(product), 32'(vecs[i].p));
      check($sformatf("vec%0d_busy_at_done", i), 32'(busy), 0);
      tick();
      check($sformatf("vec%0d_product_held", i), 32'(product), 32'(vecs[i].p));
    end

    // start re-pulsed during RUN is ignored
    a = 4'd3; b = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd7; b = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 2;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("ignore_start_latency", 32'(lat), 4);
    check("ignore_start_product", 32'(product), 15);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    check("ignore_start_single_done", 32'(extra), 0);

    // asynchronous reset mid-RUN aborts without a done pulse
    a = 4'd6; b = 4'd11; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_reset_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_product", 32'(product), 0);
    tick();
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    check("abort_no_done", 32'(extra), 0);
    run_op(4'd2, 4'd3, lat, busy_ok);
    check("post_reset_latency", 32'(lat), 4);
    check("post_reset_product", 32'(product), 6);
    tick();

    // start held high: back-to-back multiplies, done pulses WIDTH+1 cycles apart
    a = 4'd6; b = 4'd11; start = 1'b1;
    tick();
    a = 4'd15; b = 4'd15;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b_first_latency", 32'(lat), 4);
    check("b2b_first_product", 32'(product), 66);
    gap = 0;
    do begin
      tick();
      gap++;
      if (gap == 1) start = 1'b0;
    end while (done !== 1'b1 && gap < 20);
    check("b2b_gap", 32'(gap), 5);
    check("b2b_second_product", 32'(product), 225);
    tick();
    tick();

    check("single_cycle_done", 32'(dbl_done), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
